// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ceil(bin_w * log10(2)), using log10(2) ~= 0.30103
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_digit.sv
// One double-dabble correction: add 3 to a BCD nibble holding 5 or more.
module bin2bcd_digit (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one operand bit per clock,
// with valid/ready on both sides and a sticky overflow flag.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] opnd_q, opnd_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [BW-1:0]    bcd_adj;
    logic             ovf_q, ovf_d;
    logic [BW-1:0]    res_q, res_d;
    logic             res_ovf_q, res_ovf_d;
    logic             accept;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bin2bcd_digit u_dig (
            .d_i (bcd_q[4*k +: 4]),
            .d_o (bcd_adj[4*k +: 4])
        );
    end

    assign in_ready  = (state_q == IDLE) ||
                       (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign bcd_out   = res_q;
    assign overflow  = res_ovf_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    opnd_d  = in_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Nibble MSB leaving the top digit is what gets lost on overflow
                {bcd_d, opnd_d} = {bcd_adj[BW-2:0], opnd_q, 1'b0};
                ovf_d = ovf_q | bcd_adj[BW-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d   = DONE;
                    res_d     = bcd_d;
                    res_ovf_d = ovf_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised checks of bin2bcd_seq against an arithmetic BCD model,
// covering 8/3, 8/2 and 16/5 configurations.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int DB = min_digits(16);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    logic        va = 1'b0, ra = 1'b0;
    logic [7:0]  da = '0;
    logic        ir_a, ov_a, ovf_a;
    logic [11:0] bcd_a;
    logic        ir_c, ov_c, ovf_c;
    logic [7:0]  bcd_c;

    logic        vb = 1'b0, rb = 1'b0;
    logic [15:0] db = '0;
    logic        ir_b, ov_b, ovf_b;
    logic [4*DB-1:0] bcd_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir_a),
        .in_data(da), .out_valid(ov_a), .out_ready(ra),
        .bcd_out(bcd_a), .overflow(ovf_a)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir_c),
        .in_data(da), .out_valid(ov_c), .out_ready(ra),
        .bcd_out(bcd_c), .overflow(ovf_c)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(DB)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(ir_b),
        .in_data(db), .out_valid(ov_b), .out_ready(rb),
        .bcd_out(bcd_b), .overflow(ovf_b)
    );

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r = '0;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        return v >= p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        while (!ov_a && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic conv8(input logic [7:0] v);
        int n;
        va = 1'b1; da = v; ra = 1'b1;
        check("a_in_ready_idle", 32'(ir_a), 1);
        tick();
        va = 1'b0; da = 8'($urandom);
        wait_a(n);
        check("a_latency", n, 8);
        check("c_out_valid", 32'(ov_c), 1);
        check("a_bcd", 32'(bcd_a), ref_bcd(v, 3));
        check("a_ovf", 32'(ovf_a), 32'(ref_ovf(v, 3)));
        check("c_bcd", 32'(bcd_c), ref_bcd(v, 2));
        check("c_ovf", 32'(ovf_c), 32'(ref_ovf(v, 2)));
        tick();
        check("a_consumed", 32'(ov_a), 0);
    endtask

    task automatic conv16(input logic [15:0] v);
        int n;
        int stall;
        vb = 1'b1; db = v; rb = 1'b0;
        check("b_in_ready_idle", 32'(ir_b), 1);
        tick();
        vb = 1'b0; db = 16'($urandom);
        n = 0;
        while (!ov_b && n < 60) begin
            tick();
            n++;
        end
        check("b_latency", n, 16);
        check("b_bcd", 32'(bcd_b), ref_bcd(v, DB));
        check("b_ovf", 32'(ovf_b), 32'(ref_ovf(v, DB)));
        stall = $urandom_range(0, 3);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("b_hold", 32'(bcd_b), ref_bcd(v, DB));
        end
        rb = 1'b1;
        tick();
        rb = 1'b0;
        check("b_consumed", 32'(ov_b), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t[3];
        logic [7:0] vals[3];
        vals[0] = 8'd0; vals[1] = 8'd9; vals[2] = 8'd100;

        tick(); tick();
        check("rst_a_in_ready", 32'(ir_a), 1);
        check("rst_a_out_valid", 32'(ov_a), 0);
        check("rst_a_bcd", 32'(bcd_a), 0);
        check("rst_a_ovf", 32'(ovf_a), 0);
        check("rst_c_in_ready", 32'(ir_c), 1);
        check("rst_b_in_ready", 32'(ir_b), 1);
        check("rst_b_bcd", 32'(bcd_b), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        conv8(8'd255);
        conv8(8'd99);

        // back-to-back stream with in_valid and out_ready held high
        va = 1'b1; da = vals[0]; ra = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            va = (i < 2);
            da = (i < 2) ? vals[i+1] : 8'd0;
            wait_a(n);
            t[i] = cyc;
            check("b2b_bcd", 32'(bcd_a), ref_bcd(vals[i], 3));
            tick();
        end
        check("b2b_gap01", t[1] - t[0], 9);
        check("b2b_gap12", t[2] - t[1], 9);
        check("b2b_idle", 32'(ov_a), 0);

        // back-pressure: result held while in_valid/in_data wiggle
        va = 1'b1; da = 8'd200; ra = 1'b0;
        tick();
        va = 1'b0;
        wait_a(n);
        check("bp_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            va = i[0];
            da = 8'($urandom);
            #1;
            check("bp_in_ready", 32'(ir_a), 0);
            tick();
            check("bp_valid", 32'(ov_a), 1);
            check("bp_a_bcd", 32'(bcd_a), ref_bcd(200, 3));
            check("bp_c_bcd", 32'(bcd_c), ref_bcd(200, 2));
            check("bp_c_ovf", 32'(ovf_c), 32'(ref_ovf(200, 2)));
        end
        va = 1'b0; ra = 1'b1;
        #1;
        check("bp_in_ready_comb", 32'(ir_a), 1);
        tick();
        check("bp_to_idle", 32'(ov_a), 0);
        check("bp_idle_hold", 32'(bcd_a), ref_bcd(200, 3));

        // asynchronous reset in the middle of a conversion
        va = 1'b1; da = 8'd123; ra = 1'b1;
        tick();
        va = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(ov_a), 0);
        check("arst_bcd", 32'(bcd_a), 0);
        check("arst_c_ovf", 32'(ovf_c), 0);
        check("arst_in_ready", 32'(ir_a), 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        conv8(8'd42);

        for (int i = 0; i < 40; i++) conv8(8'($urandom));

        conv16(16'd65535);
        conv16(16'd0);
        conv16(16'd9999);
        conv16(16'd10000);
        for (int i = 0; i < 200; i++) conv16(16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It converts a BIN_W-bit unsigned value into DIGITS packed BCD digits. Valid/ready handshakes on input and output let it sit between the AES datapath's status/debug registers and the display/UART formatting logic. Compared with the existing 8-bit combinational encoder, it adds:
- width parametrisation;
- a bounded logic depth of one digit-correction stage per cycle;
- back-pressure;
- overflow detection.

## Interface
- BIN_W, 8: width of binary input, ≥2
- DIGITS, 3: number of BCD output digits, ≥1; output width 4*DIGITS
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data is valid
- in_ready  out  1  converter can accept in_data this cycle
- in_data  in  BIN_W  unsigned binary operand
- out_valid  out  1  bcd_out and overflow are valid
- out_ready  in  1  consumer accepts result this cycle
- bcd_out  out  4*DIGITS  packed BCD, digit k in bits [4k+3:4k], digit 0 = units
- overflow  out  1  result exceeded 10^DIGITS−1; bcd_out holds the value mod 10^DIGITS

## Operation
- States:
  - IDLE: waiting for operand.
  - SHIFT: converting.
  - DONE: result presented.
- Accept: the handshake fires on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- On accept:
  - operand register ← in_data; BCD register ← 0; bit counter ← 0; overflow ← 0; state → SHIFT.
  - in_data is ignored after the accept edge.
- SHIFT, one step per cycle:
  - Every digit ≥5 of the BCD register gets +3 (4-bit, no carry out of the nibble).
  - Then {BCD, operand} shifts left by 1.
  - overflow |= the bit shifted out of BCD MSB.
  - counter += 1.
  - After the step with counter==BIN_W−1, state → DONE.
- DONE:
  - out_valid=1; bcd_out and overflow are held stable until out_ready.
  - If out_ready and in_valid: accept the new operand, state → SHIFT.
  - If out_ready only: state → IDLE.
- out_valid is 0 in IDLE and SHIFT. bcd_out shows the final result register only. It updates only on entry to DONE and holds its last value otherwise.
- Counter width: $clog2(BIN_W). Operand register: BIN_W bits. BCD register: 4*DIGITS bits.
- Lower digits stay exact under overflow, because digit k depends only on digits ≤k.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; bcd_out=0; overflow=0; counter=0; internal registers 0.
- Latency: out_valid rises BIN_W rising edges after the accept edge.
- Throughput:
  - With out_ready held high, one result every BIN_W+1 cycles, since DONE→SHIFT accepts directly.
  - When the producer only presents data from IDLE, one result every BIN_W+2 cycles.
- out_ready→in_ready is a combinational path. No other combinational input→output path exists.
- in_valid during SHIFT is ignored; in_ready=0 there.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-conversion aborts immediately to the reset state; no partial result is presented.
- in_data=0: result 0 after BIN_W cycles. There is no early termination, so latency is data-independent.

## Structure
- Package bin2bcd_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - function min_digits(bin_w) = ceil(bin_w·log10 2), used by instantiators to size DIGITS without overflow.
- Sub-module bin2bcd_digit: 4-bit combinational add-3-if-≥5 correction, instantiated DIGITS times in a generate loop.
- The top holds the FSM, counter, operand/BCD shift registers and the output holding register. Expected size is about 150–250 lines.

## Test plan
- BIN_W=8, DIGITS=3, in_data=255, out_ready=1 → out_valid high 8 edges after accept, bcd_out=0x255, overflow=0.
- BIN_W=8, DIGITS=3, in_data=0, then 9, then 100, back-to-back with in_valid and out_ready held high → results 0x000, 0x009, 0x100, one every 9 cycles.
- BIN_W=16, DIGITS=5, in_data=65535 → bcd_out=0x65535, overflow=0. Exhaustive sweep of 0–65535 against a reference model must match.
- BIN_W=8, DIGITS=2, in_data=255 → bcd_out=0x55, overflow=1. With in_data=99 → 0x99, overflow=0.
- Result ready with out_ready low for 5 cycles while in_data/in_valid toggle → bcd_out and overflow stable, in_ready=0, no accept. out_ready high → one result consumed, then IDLE.
- rst_n pulsed low at step 4 of a BIN_W=8 conversion → outputs go to reset values asynchronously. A new operand 42 after release → 0x042 with normal latency.
